// File: rtl/inst_tx_pkg.sv
// Shared types, widths and helpers for the instruction TX scheduler.
// Default widths match the production instruction path.
package inst_tx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND,
      WAIT
   } tx_state_t;

   localparam int unsigned TXCNT_W    = 16;
   localparam int unsigned WAIT_W     = 32;
   localparam int unsigned CFG_W      = TXCNT_W + WAIT_W;
   localparam int unsigned REM_W      = TXCNT_W + 1;
   localparam int unsigned DEF_DATA_W = 512;
   localparam int unsigned DEF_TIME_W = 64;
   localparam int unsigned LOG_W      = DEF_TIME_W + DEF_DATA_W;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned p;
      r = 0;
      p = 1;
      while (p < v) begin
         p = p << 1;
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/inst_tx_queue.sv
// Pending-instruction FIFO with occupancy level and drop indication.
// When full, a push is still accepted if a pop happens in the same cycle.
module inst_tx_queue
   import inst_tx_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned LVL_W = clog2(DEPTH + 1)
) (
   input  logic             clk_sys,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic [LVL_W-1:0] level,
   output logic             drop
);

   localparam int unsigned AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign drop    = push && !do_push;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      level <= level + 1'b1;
         else if (do_pop && !do_push) level <= level - 1'b1;
      end
   end

   // Storage is not reset; only entries below level are ever read.
   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/inst_tx_sched.sv
// Instruction TX scheduler: queues instructions, replays each txcnt times
// with a configurable gap, routes to one keyer channel and logs each send.
module inst_tx_sched
   import inst_tx_pkg::*;
#(
   parameter int unsigned U_DLY       = 1,
   parameter int unsigned DATA_W      = 512,
   parameter int unsigned TIME_W      = 64,
   parameter int unsigned CH_NUM      = 2,
   parameter int unsigned QUEUE_DEPTH = 4,
   localparam int unsigned SEL_W      = (CH_NUM > 1) ? clog2(CH_NUM) : 1,
   localparam int unsigned LVL_W      = clog2(QUEUE_DEPTH + 1)
) (
   input  logic                     clk_sys,
   input  logic                     rst,
   input  logic [TXCNT_W-1:0]       cfg_ins_txcnt,
   input  logic [WAIT_W-1:0]        cfg_ins_waittime,
   input  logic [SEL_W-1:0]         cfg_ch_sel,
   input  logic                     debug_clr,
   input  logic [TIME_W-1:0]        local_time,
   input  logic [DATA_W-1:0]        inst_data,
   input  logic                     inst_data_valid,
   output logic [TIME_W+DATA_W-1:0] log_inst_data,
   output logic                     log_inst_data_valid,
   output logic [DATA_W-1:0]        ch_tx_data,
   output logic [CH_NUM-1:0]        ch_tx_valid,
   input  logic [CH_NUM-1:0]        ch_tx_ready,
   output logic                     busy,
   output logic [LVL_W-1:0]         queue_level,
   output logic                     debug_tx_overflow,
   output logic                     debug_ch_err
);

   localparam int unsigned ENTRY_W = DATA_W + SEL_W + CFG_W;

   tx_state_t          state;
   logic [ENTRY_W-1:0] q_wr_data;
   logic [ENTRY_W-1:0] q_rd_data;
   logic               q_empty;
   logic               q_pop;
   logic               q_drop;

   logic [DATA_W-1:0]  cur_data;
   logic [SEL_W-1:0]   cur_sel;
   logic [TXCNT_W-1:0] cur_txcnt;
   logic [WAIT_W-1:0]  cur_wait;
   logic [REM_W-1:0]   remaining;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [CH_NUM-1:0]  ch_onehot;
   logic               sel_ok;
   logic               handshake;

   assign q_wr_data = {inst_data, cfg_ch_sel, cfg_ins_txcnt, cfg_ins_waittime};
   assign q_pop     = (state == IDLE) && !q_empty;
   assign ch_onehot = CH_NUM'(1) << cur_sel;
   assign sel_ok    = (32'(cur_sel) < CH_NUM);
   assign handshake = |(ch_tx_valid & ch_tx_ready);

   inst_tx_queue #(
      .WIDTH (ENTRY_W),
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk_sys (clk_sys),
      .rst     (rst),
      .push    (inst_data_valid),
      .wr_data (q_wr_data),
      .pop     (q_pop),
      .rd_data (q_rd_data),
      .empty   (q_empty),
      .level   (queue_level),
      .drop    (q_drop)
   );

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state               <= IDLE;
         cur_data            <= '0;
         cur_sel             <= '0;
         cur_txcnt           <= '0;
         cur_wait            <= '0;
         remaining           <= '0;
         wait_cnt            <= '0;
         ch_tx_valid         <= '0;
         ch_tx_data          <= '0;
         log_inst_data       <= '0;
         log_inst_data_valid <= 1'b0;
         busy                <= 1'b0;
         debug_tx_overflow   <= 1'b0;
         debug_ch_err        <= 1'b0;
      end else begin
         log_inst_data_valid <= 1'b0;
         busy                <= (state != IDLE) || (queue_level != '0);

         // Clear first so a set event later in this block takes priority.
         if (debug_clr) begin
            debug_tx_overflow <= 1'b0;
            debug_ch_err      <= 1'b0;
         end
         if (q_drop) debug_tx_overflow <= 1'b1;

         case (state)
            IDLE: begin
               if (!q_empty) begin
                  {cur_data, cur_sel, cur_txcnt, cur_wait} <= q_rd_data;
                  state <= LOAD;
               end
            end
            LOAD: begin
               remaining <= (cur_txcnt == '0) ? REM_W'(1) : {1'b0, cur_txcnt};
               if (!sel_ok) begin
                  debug_ch_err <= 1'b1;
                  state        <= IDLE;
               end else begin
                  ch_tx_valid <= ch_onehot;
                  ch_tx_data  <= cur_data;
                  state       <= SEND;
               end
            end
            SEND: begin
               // Re-entry from a gap spends one cycle here with valid low.
               if (ch_tx_valid == '0) begin
                  ch_tx_valid <= ch_onehot;
               end else if (handshake) begin
                  log_inst_data       <= {local_time, cur_data};
                  log_inst_data_valid <= 1'b1;
                  ch_tx_valid         <= '0;
                  remaining           <= remaining - 1'b1;
                  if (remaining == REM_W'(1)) begin
                     state <= IDLE;
                  end else if (cur_wait != '0) begin
                     wait_cnt <= cur_wait;
                     state    <= WAIT;
                  end
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt - 1'b1;
               if (wait_cnt == WAIT_W'(1)) state <= SEND;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_tx_sched.sv
// Directed bench for inst_tx_sched: vector table plus hand-written sequences
// for stall, overflow, channel error, config capture and mid-transfer reset.
module tb_inst_tx_sched;

   localparam int unsigned DW  = 32;
   localparam int unsigned TW  = 16;
   localparam int unsigned CHN = 3;
   localparam int unsigned QD  = 4;
   localparam int unsigned SW  = 2;
   localparam int unsigned LVW = 3;

   logic              clk_sys = 1'b0;
   logic              rst;
   logic [15:0]       cfg_ins_txcnt;
   logic [31:0]       cfg_ins_waittime;
   logic [SW-1:0]     cfg_ch_sel;
   logic              debug_clr;
   logic [TW-1:0]     local_time;
   logic [DW-1:0]     inst_data;
   logic              inst_data_valid;
   logic [TW+DW-1:0]  log_inst_data;
   logic              log_inst_data_valid;
   logic [DW-1:0]     ch_tx_data;
   logic [CHN-1:0]    ch_tx_valid;
   logic [CHN-1:0]    ch_tx_ready;
   logic              busy;
   logic [LVW-1:0]    queue_level;
   logic              debug_tx_overflow;
   logic              debug_ch_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int multi_hot = 0;

   logic [DW-1:0]    hs_data[$];
   logic [CHN-1:0]   hs_vec[$];
   int               hs_cyc[$];
   logic [TW-1:0]    hs_time[$];
   logic [TW+DW-1:0] lg_data[$];
   int               lg_cyc[$];

   inst_tx_sched #(
      .DATA_W      (DW),
      .TIME_W      (TW),
      .CH_NUM      (CHN),
      .QUEUE_DEPTH (QD)
   ) dut (
      .clk_sys             (clk_sys),
      .rst                 (rst),
      .cfg_ins_txcnt       (cfg_ins_txcnt),
      .cfg_ins_waittime    (cfg_ins_waittime),
      .cfg_ch_sel          (cfg_ch_sel),
      .debug_clr           (debug_clr),
      .local_time          (local_time),
      .inst_data           (inst_data),
      .inst_data_valid     (inst_data_valid),
      .log_inst_data       (log_inst_data),
      .log_inst_data_valid (log_inst_data_valid),
      .ch_tx_data          (ch_tx_data),
      .ch_tx_valid         (ch_tx_valid),
      .ch_tx_ready         (ch_tx_ready),
      .busy                (busy),
      .queue_level         (queue_level),
      .debug_tx_overflow   (debug_tx_overflow),
      .debug_ch_err        (debug_ch_err)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;

   initial begin
      local_time = '0;
      forever begin
         @(posedge clk_sys);
         #1 local_time = local_time + 16'd3;
      end
   end

   // Observe handshakes and log pulses mid-cycle.
   always @(negedge clk_sys) begin
      if (!rst) begin
         if ($countones(ch_tx_valid) > 1) multi_hot++;
         if ((ch_tx_valid & ch_tx_ready) != '0) begin
            hs_data.push_back(ch_tx_data);
            hs_vec.push_back(ch_tx_valid);
            hs_cyc.push_back(cyc);
            hs_time.push_back(local_time);
         end
         if (log_inst_data_valid) begin
            lg_data.push_back(log_inst_data);
            lg_cyc.push_back(cyc);
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic clear_mon();
      hs_data.delete();
      hs_vec.delete();
      hs_cyc.delete();
      hs_time.delete();
      lg_data.delete();
      lg_cyc.delete();
   endtask

   task automatic write(input logic [DW-1:0] d, input logic [SW-1:0] ch,
                        input logic [15:0] cnt, input logic [31:0] wt);
      inst_data        = d;
      cfg_ch_sel       = ch;
      cfg_ins_txcnt    = cnt;
      cfg_ins_waittime = wt;
      inst_data_valid  = 1'b1;
      tick();
      inst_data_valid  = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      repeat (3) tick();
      while (busy && n < 1000) begin
         tick();
         n++;
      end
      tick();
      tick();
      chk("idle_timeout", busy, 0);
   endtask

   typedef struct {
      logic [DW-1:0]  data;
      logic [SW-1:0]  ch;
      logic [15:0]    txcnt;
      logic [31:0]    wt;
      int             exp_n;
      logic [CHN-1:0] exp_vec;
   } vec_t;

   vec_t tv[5];
   logic [DW-1:0] exp_seq[5];

   initial begin
      tv[0] = '{32'hA5A5_0001, 2'd1, 16'd3, 32'd5, 3, 3'b010};
      tv[1] = '{32'h1234_5678, 2'd0, 16'd1, 32'd0, 1, 3'b001};
      tv[2] = '{32'hDEAD_BEEF, 2'd2, 16'd0, 32'd2, 1, 3'b100};
      tv[3] = '{32'h0F0F_0F0F, 2'd0, 16'd4, 32'd0, 4, 3'b001};
      tv[4] = '{32'hCAFE_0042, 2'd1, 16'd2, 32'd1, 2, 3'b010};

      rst              = 1'b1;
      cfg_ins_txcnt    = '0;
      cfg_ins_waittime = '0;
      cfg_ch_sel       = '0;
      debug_clr        = 1'b0;
      inst_data        = '0;
      inst_data_valid  = 1'b0;
      ch_tx_ready      = '0;
      repeat (3) tick();

      chk("rst_valid", ch_tx_valid, 0);
      chk("rst_data", ch_tx_data, 0);
      chk("rst_log_valid", log_inst_data_valid, 0);
      chk("rst_log_data", log_inst_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_level", queue_level, 0);
      chk("rst_flags", {debug_tx_overflow, debug_ch_err}, 0);
      rst = 1'b0;
      tick();

      // Single-instruction vectors with ready tied high.
      for (int i = 0; i < 5; i++) begin
         clear_mon();
         ch_tx_ready = '1;
         write(tv[i].data, tv[i].ch, tv[i].txcnt, tv[i].wt);
         wait_idle();
         chk("hs_count", hs_data.size(), tv[i].exp_n);
         chk("log_count", lg_data.size(), tv[i].exp_n);
         for (int k = 0; k < hs_data.size(); k++) begin
            chk("hs_vec", hs_vec[k], tv[i].exp_vec);
            chk("hs_data", hs_data[k], tv[i].data);
            if (k < lg_data.size()) begin
               chk("log_rec", lg_data[k], {hs_time[k], tv[i].data});
               chk("log_lat", lg_cyc[k], hs_cyc[k] + 1);
            end
            if (k > 0) chk("gap", hs_cyc[k] - hs_cyc[k-1], tv[i].wt + 2);
         end
      end

      // Latency from strobe, then valid/data held while ready is low.
      clear_mon();
      ch_tx_ready = '0;
      write(32'h5555_AAAA, 2'd0, 16'd0, 32'd3);
      chk("lat_t1_valid", ch_tx_valid, 0);
      tick();
      chk("lat_t2_valid", ch_tx_valid, 0);
      tick();
      chk("lat_t3_valid", ch_tx_valid, 3'b001);
      for (int k = 0; k < 9; k++) begin
         tick();
         chk("hold_valid", ch_tx_valid, 3'b001);
         chk("hold_data", ch_tx_data, 32'h5555_AAAA);
      end
      ch_tx_ready = 3'b001;
      tick();
      ch_tx_ready = '0;
      chk("hold_log_valid", log_inst_data_valid, 1);
      chk("hold_hs_count", hs_data.size(), 1);
      if (hs_time.size() > 0)
         chk("hold_log_rec", log_inst_data, {hs_time[0], 32'h5555_AAAA});
      chk("hold_valid_off", ch_tx_valid, 0);
      chk("hold_busy_lag", busy, 1);
      tick();
      chk("hold_busy_off", busy, 0);
      chk("hold_log_pulse", log_inst_data_valid, 0);
      repeat (5) tick();
      chk("hold_log_count", lg_data.size(), 1);

      // Out-of-range channel is dropped and flagged.
      clear_mon();
      ch_tx_ready = '1;
      write(32'hBAD0_0003, 2'd3, 16'd1, 32'd0);
      repeat (8) tick();
      chk("cherr_flag", debug_ch_err, 1);
      chk("cherr_hs", hs_data.size(), 0);
      chk("cherr_log", lg_data.size(), 0);
      chk("cherr_busy", busy, 0);
      debug_clr = 1'b1;
      tick();
      debug_clr = 1'b0;
      chk("cherr_clr", debug_ch_err, 0);
      write(32'h600D_0002, 2'd2, 16'd1, 32'd0);
      wait_idle();
      chk("cherr_next_hs", hs_data.size(), 1);
      if (hs_vec.size() > 0) chk("cherr_next_vec", hs_vec[0], 3'b100);

      // Overflow while the channel is stalled on an earlier instruction.
      clear_mon();
      ch_tx_ready = '0;
      write(32'h0000_00FF, 2'd0, 16'd1, 32'd0);
      repeat (4) tick();
      exp_seq[0] = 32'h0000_00FF;
      for (int j = 1; j <= 6; j++) begin
         write(32'h0000_0100 + j, 2'd0, 16'd1, 32'd0);
         chk("ovf_level", queue_level, (j > 4) ? 4 : j);
         chk("ovf_flag", debug_tx_overflow, (j >= 5) ? 1 : 0);
         if (j <= 4) exp_seq[j] = 32'h0000_0100 + j;
      end
      ch_tx_ready = '1;
      wait_idle();
      chk("ovf_hs_count", hs_data.size(), 5);
      for (int k = 0; k < 5 && k < hs_data.size(); k++)
         chk("ovf_order", hs_data[k], exp_seq[k]);
      chk("ovf_sticky", debug_tx_overflow, 1);
      debug_clr = 1'b1;
      tick();
      debug_clr = 1'b0;
      chk("ovf_clr", debug_tx_overflow, 0);

      // Config captured per entry at write time.
      clear_mon();
      ch_tx_ready = '1;
      write(32'hAAAA_0002, 2'd1, 16'd2, 32'd0);
      write(32'hBBBB_0007, 2'd1, 16'd7, 32'd0);
      wait_idle();
      chk("cfg_hs_count", hs_data.size(), 9);
      for (int k = 0; k < hs_data.size(); k++)
         chk("cfg_order", hs_data[k], (k < 2) ? 32'hAAAA_0002 : 32'hBBBB_0007);

      // Asynchronous reset during WAIT with one entry still queued.
      clear_mon();
      ch_tx_ready = '1;
      write(32'h1111_0001, 2'd0, 16'd3, 32'd20);
      write(32'h2222_0002, 2'd0, 16'd1, 32'd0);
      for (int n = 0; n < 50 && hs_data.size() == 0; n++) tick();
      chk("rstw_first_hs", hs_data.size(), 1);
      repeat (5) tick();
      chk("rstw_level_pre", queue_level, 1);
      chk("rstw_busy_pre", busy, 1);
      rst = 1'b1;
      #1;
      chk("rstw_valid", ch_tx_valid, 0);
      chk("rstw_data", ch_tx_data, 0);
      chk("rstw_level", queue_level, 0);
      chk("rstw_busy", busy, 0);
      chk("rstw_log", {log_inst_data_valid, log_inst_data}, 0);
      tick();
      rst = 1'b0;
      clear_mon();
      repeat (40) tick();
      chk("rstw_quiet_hs", hs_data.size(), 0);
      chk("rstw_quiet_log", lg_data.size(), 0);
      write(32'h3333_0003, 2'd2, 16'd1, 32'd0);
      wait_idle();
      chk("rstw_resume_hs", hs_data.size(), 1);

      chk("onehot", multi_hot, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
